uart_rx_os16: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_os16_if.sv | 27 ++
 rtl/uart_tick_gen.sv | 29 ++
 rtl/uart_rx_os16.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_os16.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the oversample divider calculation.
package uart_pkg;

    localparam int unsigned OS_RATE    = 16;
    localparam int unsigned MID_SAMPLE = 7;
    localparam int unsigned DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    // clk cycles per oversample tick (integer truncation)
    function automatic int unsigned calc_tick_div(input int unsigned clk_freq,
                                                  input int unsigned baud_rate);
        return clk_freq / (baud_rate * OS_RATE);
    endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// Byte-side handshake between uart_rx_os16 and its consumer.
// UART_RX_PARITY_EN adds the parity_err pulse.
interface uart_rx_os16_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

`ifdef UART_RX_PARITY_EN
    modport master (output rx_data, rx_valid, frame_err, overrun, busy, parity_err,
                    input  rx_ack);
    modport slave  (input  rx_data, rx_valid, frame_err, overrun, busy, parity_err,
                    output rx_ack);
`else
    modport master (output rx_data, rx_valid, frame_err, overrun, busy,
                    input  rx_ack);
    modport slave  (input  rx_data, rx_valid, frame_err, overrun, busy,
                    output rx_ack);
`endif

endinterface

// File: rtl/uart_tick_gen.sv
// Free-running clock divider producing a one-clk tick every DIV cycles,
// with a synchronous clear to re-align the phase.
module uart_tick_gen #(
    parameter int unsigned DIV = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign tick_c = (cnt_q == CNT_W'(DIV - 1));

    // divider counter, wraps at DIV-1, cleared by rst or clr
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (tick_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampled 8N1 UART receiver with valid/ack byte handshake,
// framing-error and overrun pulses. Define UART_RX_PARITY_EN for a
// parity bit (PARITY_ODD selects odd) and the parity_err pulse.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 1000000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned TICK_DIV  = calc_tick_div(CLK_FREQ, BAUD_RATE)
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD = 1'b0
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    uart_rx_os16_if.master rx_if
);

    // divider below 2 leaves no room for a distinct tick phase
    if (TICK_DIV < 2) begin : g_tick_div_check
        $error("uart_rx_os16: TICK_DIV must be >= 2");
    end

    localparam logic [3:0] S_MID  = 4'(MID_SAMPLE);
    localparam logic [3:0] S_LAST = 4'(OS_RATE - 1);
    localparam logic [2:0] B_LAST = 3'(DATA_BITS - 1);

    logic       rx_meta;
    logic       rx_s;
    logic       tick_c;
    logic       tick_clr_c;
    logic       deliver_c;

    rx_state_t  state_q, state_d;
    logic [3:0] s_q, s_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       fe_q, fe_d;
    logic       ov_q, ov_d;
    logic       busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic       par_q, par_d;
    logic       pe_q, pe_d;
`endif

    // two-flop synchroniser for the asynchronous rx pin
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    uart_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clr    (tick_clr_c),
        .tick_c (tick_c)
    );

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            pe_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            pe_q    <= pe_d;
`endif
        end
    end

    // next-state, sampling and handshake logic
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q;
        fe_d       = 1'b0;
        ov_d       = 1'b0;
        tick_clr_c = 1'b0;
        deliver_c  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
        pe_d       = 1'b0;
`endif

        // sample counter runs only while a frame is being timed
        if (tick_c && (state_q != IDLE) && (state_q != BREAK)) begin
            s_d = s_q + 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d    = START;
                    s_d        = '0;
                    tick_clr_c = 1'b1;
                end
            end
            START: begin
                if (tick_c && (s_q == S_MID)) begin
                    if (!rx_s) begin
                        state_d = DATA;
                        s_d     = '0;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick_c && (s_q == S_LAST)) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick_c && (s_q == S_LAST)) begin
                    par_d   = rx_s;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick_c && (s_q == S_LAST)) begin
                    if (rx_s) begin
                        deliver_c = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (valid_q && rx_if.rx_ack) begin
            valid_d = 1'b0;
        end

        // a new byte overrides a same-cycle ack
        if (deliver_c) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ov_d    = valid_q && !rx_if.rx_ack;
`ifdef UART_RX_PARITY_EN
            pe_d    = ((^shift_q) ^ par_q) != PARITY_ODD;
`endif
        end

        busy_d = (state_d != IDLE);
    end

    assign rx_if.rx_data   = data_q;
    assign rx_if.rx_valid  = valid_q;
    assign rx_if.frame_err = fe_q;
    assign rx_if.overrun   = ov_q;
    assign rx_if.busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = pe_q;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16 at 1 MHz / 9600 baud (96 clk per bit).
module tb_uart_rx_os16;

    localparam int BIT = 96;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    int tests  = 0;
    int fails  = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;

    logic [7:0] f0_byte = 8'hF0;

    always #5 clk = ~clk;

    uart_rx_os16_if u_if ();

    uart_rx_os16 #(
        .CLK_FREQ  (1000000),
        .BAUD_RATE (9600)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .rx_if (u_if)
    );

    // count one-clk flag pulses
    always @(negedge clk) begin
        if (u_if.frame_err === 1'b1) fe_cnt++;
        if (u_if.overrun === 1'b1) ov_cnt++;
`ifdef UART_RX_PARITY_EN
        if (u_if.parity_err === 1'b1) pe_cnt++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        @(negedge clk);
        rx = v;
        repeat (BIT - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop_v);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_bad_par(input logic [7:0] d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(~(^d));
        drive_bit(1'b1);
    endtask
`endif

    task automatic ack_pulse();
        @(negedge clk);
        u_if.rx_ack = 1'b1;
        @(negedge clk);
        u_if.rx_ack = 1'b0;
    endtask

    initial begin
        u_if.rx_ack = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_valid", 32'(u_if.rx_valid), 32'd0);
        check("rst_data", 32'(u_if.rx_data), 32'h00);
        check("rst_busy", 32'(u_if.busy), 32'd0);
        check("rst_fe", 32'(u_if.frame_err), 32'd0);
        check("rst_ov", 32'(u_if.overrun), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // plain frame
        send_frame(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        check("a5_valid", 32'(u_if.rx_valid), 32'd1);
        check("a5_data", 32'(u_if.rx_data), 32'hA5);
        check("a5_fe", 32'(fe_cnt), 32'd0);
        check("a5_busy", 32'(u_if.busy), 32'd0);
        ack_pulse();
        check("a5_ack", 32'(u_if.rx_valid), 32'd0);
        ack_pulse();
        check("idle_ack", 32'(u_if.rx_valid), 32'd0);

        // short low glitch
        @(negedge clk);
        rx = 1'b0;
        repeat (18) @(negedge clk);
        check("glitch_busy", 32'(u_if.busy), 32'd1);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("glitch_idle", 32'(u_if.busy), 32'd0);
        check("glitch_valid", 32'(u_if.rx_valid), 32'd0);
        check("glitch_fe", 32'(fe_cnt), 32'd0);

        // framing error with held-low line
        send_frame(8'h3C, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        check("brk_busy", 32'(u_if.busy), 32'd1);
        check("brk_fe", 32'(fe_cnt), 32'd1);
        check("brk_valid", 32'(u_if.rx_valid), 32'd0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        check("brk_exit", 32'(u_if.busy), 32'd0);
        repeat (BIT) @(negedge clk);
        send_frame(8'h81, 1'b1);
        repeat (4) @(negedge clk);
        check("r81_data", 32'(u_if.rx_data), 32'h81);
        check("r81_valid", 32'(u_if.rx_valid), 32'd1);
        check("r81_fe", 32'(fe_cnt), 32'd1);
        ack_pulse();

        // back-to-back frames with ack between them
        send_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                check("b2b_first_data", 32'(u_if.rx_data), 32'h11);
                check("b2b_first_valid", 32'(u_if.rx_valid), 32'd1);
                repeat (3) @(negedge clk);
                ack_pulse();
                check("b2b_ack", 32'(u_if.rx_valid), 32'd0);
            end
        join
        repeat (4) @(negedge clk);
        check("b2b_second_data", 32'(u_if.rx_data), 32'h22);
        check("b2b_second_valid", 32'(u_if.rx_valid), 32'd1);
        check("b2b_ov", 32'(ov_cnt), 32'd0);
        ack_pulse();

        // overrun
        repeat (BIT) @(negedge clk);
        send_frame(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        check("ov_first", 32'(u_if.rx_data), 32'h55);
        send_frame(8'hAA, 1'b1);
        repeat (4) @(negedge clk);
        check("ov_pulse", 32'(ov_cnt), 32'd1);
        check("ov_data", 32'(u_if.rx_data), 32'hAA);
        check("ov_valid", 32'(u_if.rx_valid), 32'd1);

        // reset mid-frame at data bit 4
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(f0_byte[i]);
        @(negedge clk);
        rx = f0_byte[4];
        repeat (BIT / 2) @(negedge clk);
        check("mid_busy", 32'(u_if.busy), 32'd1);
        check("mid_valid", 32'(u_if.rx_valid), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_data", 32'(u_if.rx_data), 32'h00);
        check("mid_rst_valid", 32'(u_if.rx_valid), 32'd0);
        check("mid_rst_busy", 32'(u_if.busy), 32'd0);
        rst = 1'b0;
        rx = 1'b1;
        repeat (6 * BIT) @(negedge clk);
        check("post_rst_valid", 32'(u_if.rx_valid), 32'd0);
        check("post_rst_busy", 32'(u_if.busy), 32'd0);
        send_frame(8'h0F, 1'b1);
        repeat (4) @(negedge clk);
        check("r0f_data", 32'(u_if.rx_data), 32'h0F);
        check("r0f_valid", 32'(u_if.rx_valid), 32'd1);
        check("r0f_ov", 32'(ov_cnt), 32'd1);
        check("r0f_fe", 32'(fe_cnt), 32'd1);

`ifdef UART_RX_PARITY_EN
        check("par_none_yet", 32'(pe_cnt), 32'd0);
        ack_pulse();
        repeat (BIT) @(negedge clk);
        send_frame_bad_par(8'h07);
        repeat (4) @(negedge clk);
        check("par_err", 32'(pe_cnt), 32'd1);
        check("par_data", 32'(u_if.rx_data), 32'h07);
        check("par_valid", 32'(u_if.rx_valid), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
